// File: rtl/refill_way_sel.sv
// refill_way_sel: victim-way selector for set-associative cache refills.
// Prefers the lowest-index invalid unlocked way. Otherwise it picks a
// pseudo-random unlocked way, scanning upward from the LFSR index.
// The result is held in a one-entry registered slot with valid/ready.
// Optional feature macro: REFILL_WAY_SEL_STATS_EN (per-outcome accept counters).
module refill_way_sel #(
  parameter  int WIDTH    = 8,
  localparam int LogWidth = $clog2(WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [WIDTH-1:0]    way_valid_i,
  input  logic [WIDTH-1:0]    way_lock_i,
  input  logic [LogWidth-1:0] rnd_way_i,
  output logic                lfsr_en_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [WIDTH-1:0]    resp_way_oh_o,
  output logic [LogWidth-1:0] resp_way_bin_o,
  output logic                resp_invalid_o,
  output logic                resp_err_o
`ifdef REFILL_WAY_SEL_STATS_EN
  ,
  output logic [31:0]         stat_invalid_o,
  output logic [31:0]         stat_random_o,
  output logic [31:0]         stat_err_o
`endif
);

  // The way count must be a power of two that the 16-bit LFSR can index.
  if ((WIDTH < 2) || (WIDTH > 16) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
    $fatal(1, "refill_way_sel: WIDTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0]    cand;
  logic [WIDTH-1:0]    free;
  logic [LogWidth-1:0] free_bin;
  logic [LogWidth-1:0] rnd_bin;
  logic [LogWidth-1:0] scan_idx;
  logic [LogWidth-1:0] sel_bin;
  logic [WIDTH-1:0]    sel_oh;
  logic                sel_invalid;
  logic                sel_random;
  logic                sel_err;
  logic                accept;

  // A flush blocks new requests in its cycle; otherwise the slot accepts
  // whenever it is empty or is being drained.
  assign req_ready_o = !flush_i && (!resp_valid_o || resp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // Way selection from the accept-cycle inputs: invalid first, then a
  // random scan that wraps modulo WIDTH, else report that every way is locked.
  always_comb begin
    cand        = ~way_lock_i;
    free        = cand & ~way_valid_i;
    free_bin    = '0;
    rnd_bin     = '0;
    scan_idx    = '0;
    sel_bin     = '0;
    sel_oh      = '0;
    sel_invalid = 1'b0;
    sel_random  = 1'b0;
    sel_err     = 1'b0;
    // Descending loops leave the lowest qualifying hit as the final assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_bin = LogWidth'(i);
      end else begin
        free_bin = free_bin;
      end
    end
    for (int j = WIDTH - 1; j >= 0; j--) begin
      scan_idx = rnd_way_i + LogWidth'(j);
      if (cand[scan_idx]) begin
        rnd_bin = scan_idx;
      end else begin
        rnd_bin = rnd_bin;
      end
    end
    if (|free) begin
      sel_bin     = free_bin;
      sel_invalid = 1'b1;
    end else if (|cand) begin
      sel_bin    = rnd_bin;
      sel_random = 1'b1;
    end else begin
      sel_err = 1'b1;
    end
    if (!sel_err) begin
      sel_oh[sel_bin] = 1'b1;
    end else begin
      sel_oh = '0;
    end
  end

  // The LFSR advances only when a random pick is actually accepted.
  assign lfsr_en_o = accept && sel_random && !rst_i;

  // Response slot: flush beats accept, accept beats drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o   <= 1'b0;
      resp_way_oh_o  <= '0;
      resp_way_bin_o <= '0;
      resp_invalid_o <= 1'b0;
      resp_err_o     <= 1'b0;
    end else if (flush_i) begin
      resp_valid_o <= 1'b0;
    end else if (accept) begin
      resp_valid_o   <= 1'b1;
      resp_way_oh_o  <= sel_oh;
      resp_way_bin_o <= sel_bin;
      resp_invalid_o <= sel_invalid;
      resp_err_o     <= sel_err;
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
  end

`ifdef REFILL_WAY_SEL_STATS_EN
  // Saturating per-outcome counters of accepted requests; flush leaves them alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_invalid_o <= 32'd0;
      stat_random_o  <= 32'd0;
      stat_err_o     <= 32'd0;
    end else if (accept) begin
      if (sel_invalid && (stat_invalid_o != 32'hFFFF_FFFF)) begin
        stat_invalid_o <= stat_invalid_o + 32'd1;
      end
      if (sel_random && (stat_random_o != 32'hFFFF_FFFF)) begin
        stat_random_o <= stat_random_o + 32'd1;
      end
      if (sel_err && (stat_err_o != 32'hFFFF_FFFF)) begin
        stat_err_o <= stat_err_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_refill_way_sel.sv
// Self-checking bench for refill_way_sel (WIDTH=8): directed vector table,
// hand-written handshake/flush/reset sequences, and randomized traffic
// compared against a behavioural model of the selection rules.
module tb_refill_way_sel;

  localparam int W  = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  way_valid;
  logic [W-1:0]  way_lock;
  logic [LW-1:0] rnd_way;
  logic          lfsr_en;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_way_oh;
  logic [LW-1:0] resp_way_bin;
  logic          resp_invalid;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the response slot.
  logic m_valid = 1'b0;
  int   m_way   = 0;
  logic m_inv   = 1'b0;
  logic m_err   = 1'b0;

  refill_way_sel #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .way_valid_i    (way_valid),
    .way_lock_i     (way_lock),
    .rnd_way_i      (rnd_way),
    .lfsr_en_o      (lfsr_en),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_way_oh_o  (resp_way_oh),
    .resp_way_bin_o (resp_way_bin),
    .resp_invalid_o (resp_invalid),
    .resp_err_o     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // kind: 0 = invalid way, 1 = random pick, 2 = all locked (way = -1)
  function automatic int pick_way(input logic [W-1:0] v, input logic [W-1:0] l,
                                  input int r, output int kind);
    for (int k = 0; k < W; k++) begin
      if (!l[k] && !v[k]) begin
        kind = 0;
        return k;
      end
    end
    for (int k = 0; k < W; k++) begin
      int w;
      w = (r + k) % W;
      if (!l[w]) begin
        kind = 1;
        return w;
      end
    end
    kind = 2;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_oh();
    logic [W-1:0] one;
    one = 1;
    return m_err ? '0 : (one << m_way);
  endfunction

  // One clock cycle, started just after a falling edge.
  task automatic step(input logic rv, input logic rr, input logic fl,
                      input logic [W-1:0] v, input logic [W-1:0] l,
                      input logic [LW-1:0] r, output logic lf_seen);
    int   kind;
    int   way;
    logic exp_ready;
    logic acc;
    req_valid  = rv;
    resp_ready = rr;
    flush      = fl;
    way_valid  = v;
    way_lock   = l;
    rnd_way    = r;
    #1;
    way       = pick_way(v, l, int'(r), kind);
    exp_ready = !fl && (!m_valid || rr);
    acc       = rv && exp_ready;
    lf_seen   = lfsr_en;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    check("lfsr_en", {31'd0, lfsr_en}, {31'd0, acc && (kind == 1)});
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_way   = (kind == 2) ? 0 : way;
      m_inv   = (kind == 0);
      m_err   = (kind == 2);
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("resp_bin", {29'd0, resp_way_bin}, m_way);
      check("resp_oh", {24'd0, resp_way_oh}, {24'd0, model_oh()});
      check("resp_invalid", {31'd0, resp_invalid}, {31'd0, m_inv});
      check("resp_err", {31'd0, resp_err}, {31'd0, m_err});
    end
  endtask

  typedef struct {
    logic [W-1:0]  v;
    logic [W-1:0]  l;
    logic [LW-1:0] r;
    logic [LW-1:0] bin;
    logic [W-1:0]  oh;
    logic          inv;
    logic          err;
    logic          lf;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic          lf;
    logic [W-1:0]  v;
    logic [W-1:0]  l;
    tbl[0] = '{v: 8'hFF, l: 8'h00, r: 3'd5, bin: 3'd5, oh: 8'h20, inv: 1'b0, err: 1'b0, lf: 1'b1};
    tbl[1] = '{v: 8'hF3, l: 8'h04, r: 3'd0, bin: 3'd3, oh: 8'h08, inv: 1'b1, err: 1'b0, lf: 1'b0};
    tbl[2] = '{v: 8'hFF, l: 8'hE0, r: 3'd6, bin: 3'd0, oh: 8'h01, inv: 1'b0, err: 1'b0, lf: 1'b1};
    tbl[3] = '{v: 8'hFF, l: 8'hFF, r: 3'd3, bin: 3'd0, oh: 8'h00, inv: 1'b0, err: 1'b1, lf: 1'b0};
    tbl[4] = '{v: 8'h00, l: 8'h00, r: 3'd4, bin: 3'd0, oh: 8'h01, inv: 1'b1, err: 1'b0, lf: 1'b0};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    way_valid = '0; way_lock = '0; rnd_way = '0;
    #12;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_oh", {24'd0, resp_way_oh}, 32'd0);
    check("rst_bin", {29'd0, resp_way_bin}, 32'd0);
    check("rst_inv_err", {30'd0, resp_invalid, resp_err}, 32'd0);
    check("rst_lfsr", {31'd0, lfsr_en}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, each drained before the next.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, tbl[i].v, tbl[i].l, tbl[i].r, lf);
      check("tbl_lfsr", {31'd0, lf}, {31'd0, tbl[i].lf});
      check("tbl_valid", {31'd0, resp_valid}, 32'd1);
      check("tbl_bin", {29'd0, resp_way_bin}, {29'd0, tbl[i].bin});
      check("tbl_oh", {24'd0, resp_way_oh}, {24'd0, tbl[i].oh});
      check("tbl_inv", {31'd0, resp_invalid}, {31'd0, tbl[i].inv});
      check("tbl_err", {31'd0, resp_err}, {31'd0, tbl[i].err});
      step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, lf);
      check("tbl_lfsr_idle", {31'd0, lf}, 32'd0);
    end

    // Back-to-back accepts, then hold with consumer stalled.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom), LW'($urandom), lf);
      check("b2b_valid", {31'd0, resp_valid}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, LW'(i), lf);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end

    // Flush while full and a random-pick request is offered.
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 3'd2, lf);
    check("flush_lfsr", {31'd0, lf}, 32'd0);
    check("flush_valid", {31'd0, resp_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           v, l, LW'($urandom), lf);
    end

    // Reset while holding a response with a random-pick request pending.
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd1, lf);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd1, lf);
    check("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_oh", {24'd0, resp_way_oh}, 32'd0);
    check("mid_rst_bin", {29'd0, resp_way_bin}, 32'd0);
    check("mid_rst_inv_err", {30'd0, resp_invalid, resp_err}, 32'd0);
    check("mid_rst_lfsr", {31'd0, lfsr_en}, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, lf);
    check("post_rst_valid", {31'd0, resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
